// File: rtl/noc_mux_framer.sv
// noc_mux_framer
//   Multi-channel transmit framer for the device-to-NoC byte link. Each of NCH
//   upstream channels writes into its own store-and-forward FIFO. A round-robin
//   arbiter picks among channels holding at least one complete packet. The
//   winning packet is emitted as one header beat (ctl=1, data=channel index)
//   followed by its payload beats (ctl=0). Idle beats are ctl=1, data=all ones.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-low reset
//   link_en              when low, the packet in flight finishes, then the link idles
//   in_valid/data/last   per-channel write beats; channel c uses in_data[c*DW +: DW]
//   in_ready             per-channel FIFO not full
//   noc_from_dev_ctl     1 = header/idle beat, 0 = payload beat (registered)
//   noc_from_dev_data    beat data (registered)
//   pkt_sent             pulses while the final payload beat is driven
//   err_oversize         per-channel pulse when a packet was truncated at FIFO depth
//   busy                 high in HEADER or PAYLOAD state
module noc_mux_framer #(
  parameter int NCH   = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              link_en,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_last,
  output logic [NCH-1:0]    in_ready,
  output logic              noc_from_dev_ctl,
  output logic [DW-1:0]     noc_from_dev_data,
  output logic              pkt_sent,
  output logic [NCH-1:0]    err_oversize,
  output logic              busy
);

  localparam int          AW            = $clog2(DEPTH);
  localparam int          CW            = $clog2(NCH);
  localparam int unsigned NCH_U         = NCH;
  localparam logic [AW:0] CNT_FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_LAST_FREE = (AW+1)'(DEPTH - 1);
  localparam logic [CW-1:0] CH_MAX      = CW'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD
  } state_e;

  state_e state_q, state_d;

  // Per-channel FIFO storage: each word is {last, data}
  logic [DW:0]     mem_q      [NCH][DEPTH];
  logic [AW-1:0]   wr_ptr_q   [NCH];
  logic [AW-1:0]   wr_ptr_d   [NCH];
  logic [AW-1:0]   rd_ptr_q   [NCH];
  logic [AW-1:0]   rd_ptr_d   [NCH];
  logic [AW:0]     cnt_q      [NCH];
  logic [AW:0]     cnt_d      [NCH];
  logic [AW:0]     pkt_cnt_q  [NCH];
  logic [AW:0]     pkt_cnt_d  [NCH];

  logic [NCH-1:0]  push;
  logic [NCH-1:0]  pop;
  logic [NCH-1:0]  wr_last;
  logic [NCH-1:0]  trunc;
  logic [NCH-1:0]  err_q, err_d;

  logic [CW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cur_ch_q, cur_ch_d;
  logic [CW-1:0]   arb_ch;
  logic [CW-1:0]   arb_next;
  logic [CW-1:0]   idx_c;
  int unsigned     idx;
  logic            arb_found;

  logic            pop_en;
  logic [DW:0]     rd_word;

  logic            ctl_q, ctl_d;
  logic [DW-1:0]   data_q, data_d;
  logic            sent_q, sent_d;
  logic            last_out_q, last_out_d;

  assign rd_word = mem_q[cur_ch_q][rd_ptr_q[cur_ch_q]];

  // Write side, FIFO occupancy and complete-packet counters
  always_comb begin
    for (int unsigned c = 0; c < NCH_U; c++) begin
      in_ready[c] = (cnt_q[c] != CNT_FULL);
      push[c]     = in_valid[c] & in_ready[c];
      // Filling the last free slot with no complete packet inside would
      // deadlock the channel, so that beat closes the packet instead.
      trunc[c]    = push[c] & ~in_last[c] & (cnt_q[c] == CNT_LAST_FREE) &
                    (pkt_cnt_q[c] == '0);
      wr_last[c]  = in_last[c] | trunc[c];
      pop[c]      = pop_en & (cur_ch_q == CW'(c));
      err_d[c]    = trunc[c];

      wr_ptr_d[c] = push[c] ? wr_ptr_q[c] + AW'(1) : wr_ptr_q[c];
      rd_ptr_d[c] = pop[c]  ? rd_ptr_q[c] + AW'(1) : rd_ptr_q[c];

      cnt_d[c] = cnt_q[c];
      if (push[c] && !pop[c]) begin
        cnt_d[c] = cnt_q[c] + (AW+1)'(1);
      end else if (!push[c] && pop[c]) begin
        cnt_d[c] = cnt_q[c] - (AW+1)'(1);
      end

      pkt_cnt_d[c] = pkt_cnt_q[c];
      if ((push[c] && wr_last[c]) && !(pop[c] && rd_word[DW])) begin
        pkt_cnt_d[c] = pkt_cnt_q[c] + (AW+1)'(1);
      end else if (!(push[c] && wr_last[c]) && (pop[c] && rd_word[DW])) begin
        pkt_cnt_d[c] = pkt_cnt_q[c] - (AW+1)'(1);
      end
    end
  end

  // Round-robin: first channel at or after rr_q (wrapping) with a full packet
  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    idx       = 0;
    idx_c     = '0;
    for (int unsigned i = 0; i < NCH_U; i++) begin
      idx   = (32'(rr_q) + i) % NCH_U;
      idx_c = CW'(idx);
      if (!arb_found && (pkt_cnt_q[idx_c] != '0)) begin
        arb_found = 1'b1;
        arb_ch    = idx_c;
      end
    end
    arb_next = (arb_ch == CH_MAX) ? '0 : arb_ch + CW'(1);
  end

  // Framing FSM; outputs are computed here and registered
  always_comb begin
    logic start_hdr;
    state_d    = state_q;
    ctl_d      = 1'b1;
    data_d     = '1;
    sent_d     = 1'b0;
    last_out_d = last_out_q;
    cur_ch_d   = cur_ch_q;
    rr_d       = rr_q;
    pop_en     = 1'b0;
    start_hdr  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start_hdr = link_en & arb_found;
        if (!start_hdr) begin
          state_d = ST_IDLE;
        end
      end
      ST_HEADER: begin
        pop_en = 1'b1;
      end
      ST_PAYLOAD: begin
        // last_out_q marks the word currently on the link as the packet end
        if (!last_out_q) begin
          pop_en = 1'b1;
        end else if (link_en && arb_found) begin
          start_hdr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop_en) begin
      state_d    = ST_PAYLOAD;
      ctl_d      = 1'b0;
      data_d     = rd_word[DW-1:0];
      last_out_d = rd_word[DW];
      sent_d     = rd_word[DW];
    end

    if (start_hdr) begin
      state_d    = ST_HEADER;
      ctl_d      = 1'b1;
      data_d     = DW'(arb_ch);
      cur_ch_d   = arb_ch;
      rr_d       = arb_next;
      last_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      cur_ch_q   <= '0;
      ctl_q      <= 1'b1;
      data_q     <= '1;
      sent_q     <= 1'b0;
      last_out_q <= 1'b0;
      err_q      <= '0;
      for (int unsigned c = 0; c < NCH_U; c++) begin
        wr_ptr_q[c]  <= '0;
        rd_ptr_q[c]  <= '0;
        cnt_q[c]     <= '0;
        pkt_cnt_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cur_ch_q   <= cur_ch_d;
      ctl_q      <= ctl_d;
      data_q     <= data_d;
      sent_q     <= sent_d;
      last_out_q <= last_out_d;
      err_q      <= err_d;
      for (int unsigned c = 0; c < NCH_U; c++) begin
        wr_ptr_q[c]  <= wr_ptr_d[c];
        rd_ptr_q[c]  <= rd_ptr_d[c];
        cnt_q[c]     <= cnt_d[c];
        pkt_cnt_q[c] <= pkt_cnt_d[c];
      end
    end
  end

  // Storage needs no reset: pointers and counters define what is valid
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH_U; c++) begin
      if (push[c]) begin
        mem_q[c][wr_ptr_q[c]] <= {wr_last[c], in_data[c*DW +: DW]};
      end
    end
  end

  assign noc_from_dev_ctl  = ctl_q;
  assign noc_from_dev_data = data_q;
  assign pkt_sent          = sent_q;
  assign err_oversize      = err_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_noc_mux_framer.sv
// tb_noc_mux_framer
//   Directed bench for noc_mux_framer (NCH=4, DW=8, DEPTH=16). Every cycle the
//   link state {busy, pkt_sent, ctl, data} is logged shortly after the rising
//   edge; each scenario task compares a window of that log against a
//   hand-built expected beat sequence.
module tb_noc_mux_framer;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  localparam logic [10:0] IDLE = 11'h1FF;

  logic              clk = 1'b0;
  logic              reset;
  logic              link_en;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_last;
  logic [NCH-1:0]    in_ready;
  logic              noc_from_dev_ctl;
  logic [DW-1:0]     noc_from_dev_data;
  logic              pkt_sent;
  logic [NCH-1:0]    err_oversize;
  logic              busy;

  int vectors    = 0;
  int miscompares = 0;

  logic [10:0] log_q[$];
  int          err_pulses[NCH];

  noc_mux_framer #(
    .NCH   (NCH),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .link_en           (link_en),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .noc_from_dev_ctl  (noc_from_dev_ctl),
    .noc_from_dev_data (noc_from_dev_data),
    .pkt_sent          (pkt_sent),
    .err_oversize      (err_oversize),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int c = 0; c < NCH; c++) err_pulses[c] = 0;
  end

  always @(posedge clk) begin
    #1;
    log_q.push_back({busy, pkt_sent, noc_from_dev_ctl, noc_from_dev_data});
    for (int c = 0; c < NCH; c++) begin
      if (err_oversize[c] === 1'b1) err_pulses[c] = err_pulses[c] + 1;
    end
  end

  function automatic logic [10:0] hdr(input logic [7:0] c);
    return {1'b1, 1'b0, 1'b1, c};
  endfunction

  function automatic logic [10:0] pl(input logic [7:0] d);
    return {1'b1, 1'b0, 1'b0, d};
  endfunction

  function automatic logic [10:0] pll(input logic [7:0] d);
    return {1'b1, 1'b1, 1'b0, d};
  endfunction

  // Drive one beat from a negedge and return at the negedge after acceptance
  task automatic push_beat(input int unsigned ch, input logic [7:0] d, input logic last);
    logic        acc;
    int unsigned waited;
    acc    = 1'b0;
    waited = 0;
    in_valid[ch]       = 1'b1;
    in_data[ch*8 +: 8] = d;
    in_last[ch]        = last;
    while (!acc && waited < 200) begin
      acc = in_ready[ch];
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    in_valid[ch] = 1'b0;
    in_last[ch]  = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL push_ch%0d: in_ready got 0, expected 1 within 200 cycles", ch);
    end
  endtask

  task automatic test_reset();
    int base;
    reset    = 1'b0;
    link_en  = 1'b1;
    in_valid = '1;
    in_last  = '1;
    in_data  = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (noc_from_dev_ctl !== 1'b1) begin
      miscompares++; $display("FAIL reset_ctl: got %b expected 1", noc_from_dev_ctl);
    end
    vectors++;
    if (noc_from_dev_data !== 8'hFF) begin
      miscompares++; $display("FAIL reset_data: got %h expected ff", noc_from_dev_data);
    end
    vectors++;
    if (in_ready !== 4'hF) begin
      miscompares++; $display("FAIL reset_in_ready: got %h expected f", in_ready);
    end
    vectors++;
    if (pkt_sent !== 1'b0) begin
      miscompares++; $display("FAIL reset_pkt_sent: got %b expected 0", pkt_sent);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if (err_oversize !== 4'h0) begin
      miscompares++; $display("FAIL reset_err: got %h expected 0", err_oversize);
    end
    in_valid = '0;
    in_last  = '0;
    reset    = 1'b1;
    base     = log_q.size();
    repeat (6) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (log_q[base+k] !== IDLE) begin
        miscompares++;
        $display("FAIL post_reset_idle[%0d]: got %h expected %h", k, log_q[base+k], IDLE);
      end
    end
    vectors++;
    if (in_ready !== 4'hF) begin
      miscompares++; $display("FAIL post_reset_in_ready: got %h expected f", in_ready);
    end
  endtask

  task automatic test_single_packet();
    int base;
    logic [10:0] exp_q[$];
    base = log_q.size();
    push_beat(2, 8'hA1, 1'b0);
    push_beat(2, 8'hA2, 1'b0);
    push_beat(2, 8'hA3, 1'b1);
    repeat (6) @(negedge clk);
    exp_q = {IDLE, IDLE, IDLE, hdr(8'h02), pl(8'hA1), pl(8'hA2), pll(8'hA3), IDLE, IDLE};
    vectors++;
    if (log_q.size() < base + exp_q.size()) begin
      miscompares++; $display("FAIL single_len: got %0d expected >= %0d", log_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (log_q[base+k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL single[%0d]: got %h expected %h", k, log_q[base+k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int base;
    logic [10:0] exp_q[$];
    // rr pointer sits at 3 after the ch2 packet: ch3 wins first, then wraps to ch0
    base     = log_q.size();
    in_valid = 4'b1001;
    in_data  = {8'h30, 8'h00, 8'h00, 8'h10};
    in_last  = 4'b0000;
    @(negedge clk);
    in_data  = {8'h31, 8'h00, 8'h00, 8'h11};
    in_last  = 4'b1001;
    @(negedge clk);
    in_valid = '0;
    in_last  = '0;
    repeat (8) @(negedge clk);
    exp_q = {IDLE, IDLE, hdr(8'h03), pl(8'h30), pll(8'h31),
             hdr(8'h00), pl(8'h10), pll(8'h11), IDLE, IDLE};
    vectors++;
    if (log_q.size() < base + exp_q.size()) begin
      miscompares++; $display("FAIL rr1_len: got %0d expected >= %0d", log_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (log_q[base+k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL rr1[%0d]: got %h expected %h", k, log_q[base+k], exp_q[k]);
        end
      end
    end

    // rr pointer now 1: order ch1, ch3, ch0
    base     = log_q.size();
    in_valid = 4'b1011;
    in_data  = {8'h30, 8'h00, 8'h20, 8'h10};
    in_last  = 4'b0000;
    @(negedge clk);
    in_data  = {8'h31, 8'h00, 8'h21, 8'h11};
    in_last  = 4'b1011;
    @(negedge clk);
    in_valid = '0;
    in_last  = '0;
    repeat (10) @(negedge clk);
    exp_q = {IDLE, IDLE, hdr(8'h01), pl(8'h20), pll(8'h21),
             hdr(8'h03), pl(8'h30), pll(8'h31),
             hdr(8'h00), pl(8'h10), pll(8'h11), IDLE};
    vectors++;
    if (log_q.size() < base + exp_q.size()) begin
      miscompares++; $display("FAIL rr2_len: got %0d expected >= %0d", log_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (log_q[base+k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL rr2[%0d]: got %h expected %h", k, log_q[base+k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_oversize();
    int base;
    int h;
    int e_before[NCH];
    int others;
    logic [10:0] exp_q[$];
    for (int c = 0; c < NCH; c++) e_before[c] = err_pulses[c];
    link_en = 1'b0;
    base    = log_q.size();
    fork
      begin
        for (int k = 1; k <= 20; k++) begin
          push_beat(1, 8'(8'h40 + k), (k == 20));
        end
      end
      begin
        repeat (25) @(negedge clk);
        link_en = 1'b1;
      end
    join
    repeat (30) @(negedge clk);

    vectors++;
    if (err_pulses[1] - e_before[1] !== 1) begin
      miscompares++;
      $display("FAIL oversize_err1: got %0d pulses expected 1", err_pulses[1] - e_before[1]);
    end
    others = 0;
    for (int c = 0; c < NCH; c++) if (c != 1) others += err_pulses[c] - e_before[c];
    vectors++;
    if (others !== 0) begin
      miscompares++; $display("FAIL oversize_err_other: got %0d pulses expected 0", others);
    end

    h = -1;
    for (int k = 0; base + k < log_q.size(); k++) begin
      if (h < 0 && log_q[base+k] !== IDLE) h = k;
    end
    vectors++;
    if (h !== 25) begin
      miscompares++; $display("FAIL oversize_hdr_cycle: got %0d expected 25", h);
    end

    exp_q.push_back(hdr(8'h01));
    for (int k = 1; k <= 15; k++) exp_q.push_back(pl(8'(8'h40 + k)));
    exp_q.push_back(pll(8'h50));
    exp_q.push_back(hdr(8'h01));
    for (int k = 17; k <= 19; k++) exp_q.push_back(pl(8'(8'h40 + k)));
    exp_q.push_back(pll(8'h54));
    exp_q.push_back(IDLE);
    vectors++;
    if (h < 0 || log_q.size() < base + h + exp_q.size()) begin
      miscompares++; $display("FAIL oversize_len: got start %0d expected a complete stream", h);
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (log_q[base+h+k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL oversize[%0d]: got %h expected %h", k, log_q[base+h+k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_link_en_drop();
    int base;
    logic [10:0] exp_q[$];
    link_en = 1'b0;
    for (int k = 0; k < 5; k++) push_beat(0, 8'(8'h60 + k), (k == 4));
    push_beat(0, 8'h70, 1'b0);
    push_beat(0, 8'h71, 1'b1);
    repeat (2) @(negedge clk);
    base    = log_q.size();
    link_en = 1'b1;
    repeat (3) @(negedge clk);
    link_en = 1'b0;
    repeat (8) @(negedge clk);
    link_en = 1'b1;
    repeat (6) @(negedge clk);
    exp_q = {hdr(8'h00), pl(8'h60), pl(8'h61), pl(8'h62), pl(8'h63), pll(8'h64),
             IDLE, IDLE, IDLE, IDLE, IDLE,
             hdr(8'h00), pl(8'h70), pll(8'h71), IDLE, IDLE, IDLE};
    vectors++;
    if (log_q.size() < base + exp_q.size()) begin
      miscompares++; $display("FAIL link_en_len: got %0d expected >= %0d", log_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (log_q[base+k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL link_en[%0d]: got %h expected %h", k, log_q[base+k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int base;
    logic [10:0] exp_q[$];
    link_en = 1'b1;
    base    = log_q.size();
    for (int k = 0; k < 6; k++) push_beat(2, 8'(8'h80 + k), (k == 5));
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (noc_from_dev_ctl !== 1'b1 || noc_from_dev_data !== 8'hFF) begin
      miscompares++;
      $display("FAIL midrst_idle: got %b/%h expected 1/ff", noc_from_dev_ctl, noc_from_dev_data);
    end
    vectors++;
    if (in_ready !== 4'hF) begin
      miscompares++; $display("FAIL midrst_in_ready: got %h expected f", in_ready);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy);
    end
    reset = 1'b1;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 6; k++) exp_q.push_back(IDLE);
    exp_q.push_back(hdr(8'h02));
    exp_q.push_back(pl(8'h80));
    exp_q.push_back(pl(8'h81));
    exp_q.push_back(pl(8'h82));
    for (int k = 0; k < 9; k++) exp_q.push_back(IDLE);
    vectors++;
    if (log_q.size() < base + exp_q.size()) begin
      miscompares++; $display("FAIL midrst_len: got %0d expected >= %0d", log_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        vectors++;
        if (log_q[base+k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL midrst[%0d]: got %h expected %h", k, log_q[base+k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    link_en  = 1'b1;
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    @(negedge clk);
    test_reset();
    test_single_packet();
    test_round_robin();
    test_oversize();
    test_link_en_drop();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1);
  end

endmodule
